// File: rtl/npc_bpred_unit.sv
// npc_bpred_unit: next-PC generator for the IF stage.
//
// Owns the fetch PC register and a direct-mapped BTB with saturating
// direction counters. Every cycle it predicts the next fetch address from
// the BTB entry selected by pc_o. Resolved control flow arriving from EX
// trains the BTB, and a misprediction raises flush_o and redirects fetch.
// JALR is never predicted; it always resolves through the redirect path.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   stall           hold the fetch PC (a redirect still loads)
//   pc_o            registered fetch PC
//   npc_o           combinational next fetch PC
//   pred_taken_o    prediction for pc_o
//   pred_target_o   predicted target for pc_o
//   ex_valid        EX holds a valid control-flow instruction
//   ex_type         00 branch, 01 JAL, 10 JALR, 11 reserved (no-op)
//   ex_pc           PC of the EX instruction
//   ex_taken        resolved direction
//   ex_target       resolved target
//   ex_pred_taken   prediction carried down with the EX instruction
//   ex_pred_target  predicted target carried down with the EX instruction
//   flush_o         misprediction, kill IF and ID
//   br_cnt_o        resolved control-flow count (saturating)
//   mispred_cnt_o   misprediction count (saturating)
module npc_bpred_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter int unsigned     CNT_BITS    = 2,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            ex_valid,
    input  logic [1:0]      ex_type,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush_o,
    output logic [31:0]     br_cnt_o,
    output logic [31:0]     mispred_cnt_o
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    localparam logic [1:0] TypeBranch = 2'b00;
    localparam logic [1:0] TypeJal    = 2'b01;
    localparam logic [1:0] TypeRsvd   = 2'b11;

    localparam logic [CNT_BITS-1:0] CntMax  = '1;
    localparam logic [CNT_BITS-1:0] CntWeak = CNT_BITS'(1 << (CNT_BITS - 1));

    // BTB storage
    logic                r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]    r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]     r_target [BTB_ENTRIES];
    logic                r_is_jal [BTB_ENTRIES];
    logic [CNT_BITS-1:0] r_cnt    [BTB_ENTRIES];

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_br_cnt;
    logic [31:0]     r_mispred_cnt;

    logic [IDX-1:0]      w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic [XLEN-1:0]     w_pc_plus4;
    logic [IDX-1:0]      w_ex_idx;
    logic [TAG_W-1:0]    w_ex_tag;
    logic                w_ex_hit;
    logic [CNT_BITS-1:0] w_ex_cnt_next;
    logic                w_ctrl;
    logic                w_mispred;
    logic [XLEN-1:0]     w_redirect;

    assign pc_o = r_pc;

    // Fetch-side lookup
    assign w_idx      = r_pc[IDX+1:2];
    assign w_tag      = r_pc[XLEN-1:IDX+2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pc_plus4 = r_pc + XLEN'(4);

    assign pred_taken_o  = w_hit && (r_is_jal[w_idx] || r_cnt[w_idx][CNT_BITS-1]);
    assign pred_target_o = w_hit ? r_target[w_idx] : w_pc_plus4;

    // EX-side resolution
    assign w_ctrl     = ex_valid && (ex_type != TypeRsvd);
    assign w_mispred  = w_ctrl && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)));
    assign w_redirect = ex_taken ? ex_target : (ex_pc + XLEN'(4));
    assign flush_o    = w_mispred;

    always_comb begin
        npc_o = w_pc_plus4;
        if (w_mispred) begin
            npc_o = w_redirect;
        end else if (pred_taken_o) begin
            npc_o = pred_target_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (!stall || w_mispred) begin
            r_pc <= npc_o;
        end
    end

    // Training lookup on the EX instruction's slot
    assign w_ex_idx = ex_pc[IDX+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:IDX+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_comb begin
        w_ex_cnt_next = r_cnt[w_ex_idx];
        if (ex_taken && (r_cnt[w_ex_idx] != CntMax)) begin
            w_ex_cnt_next = r_cnt[w_ex_idx] + CNT_BITS'(1);
        end else if (!ex_taken && (r_cnt[w_ex_idx] != '0)) begin
            w_ex_cnt_next = r_cnt[w_ex_idx] - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_is_jal[i] <= 1'b0;
                r_cnt[i]    <= '0;
            end
        end else if (ex_valid) begin
            case (ex_type)
                TypeBranch: begin
                    if (w_ex_hit) begin
                        r_cnt[w_ex_idx] <= w_ex_cnt_next;
                        if (ex_taken) begin
                            r_target[w_ex_idx] <= ex_target;
                        end
                    end else if (ex_taken) begin
                        // Only taken branches earn a slot; start weakly taken.
                        r_valid[w_ex_idx]  <= 1'b1;
                        r_tag[w_ex_idx]    <= w_ex_tag;
                        r_target[w_ex_idx] <= ex_target;
                        r_is_jal[w_ex_idx] <= 1'b0;
                        r_cnt[w_ex_idx]    <= CntWeak;
                    end
                end
                TypeJal: begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= ex_target;
                    r_is_jal[w_ex_idx] <= 1'b1;
                    r_cnt[w_ex_idx]    <= CntMax;
                end
                default: begin
                    // JALR and reserved never touch the BTB.
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_ctrl && (r_br_cnt != '1)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule
